// File: rtl/spio_hss_multiplexer_tx_arbiter_pkg.sv
// Shared widths, control-word codes and FSM states for the HSS multiplexer transmit arbiter.
package spio_hss_multiplexer_tx_arbiter_pkg;

    localparam int FRM_BITS  = 32;
    localparam int KCH_BITS  = 4;
    localparam int CLR_BITS  = 1;
    localparam int SEQ_BITS  = 7;
    localparam int NUM_CHANS = 8;

    localparam logic [7:0] CODE_IDLE = 8'hBC;
    localparam logic [7:0] CODE_ACK  = 8'h3C;
    localparam logic [7:0] CODE_NAK  = 8'h5C;
    localparam logic [7:0] CODE_OOC  = 8'h7C;
    localparam logic [7:0] CODE_CLKC = 8'h9C;

    localparam logic [KCH_BITS-1:0] CTL_KCHR = 4'b1000;

    typedef enum logic {
        ST_BOUNDARY,
        ST_DATA
    } tx_state_e;

    // Control word layout: code | cfc_loc | colour | seq, each field zero-extended to a byte.
    function automatic logic [FRM_BITS-1:0] ctl_word(input logic [7:0]           code,
                                                     input logic [NUM_CHANS-1:0] cfc,
                                                     input logic [CLR_BITS-1:0]  colour,
                                                     input logic [SEQ_BITS-1:0]  seq);
        return {code, 8'(cfc), 8'(colour), 8'(seq)};
    endfunction

endpackage

// File: rtl/spio_hss_multiplexer_tx_arbiter_if.sv
// Source-side and link-side signals of the transmit arbiter; slave = arbiter, master = environment.
interface spio_hss_multiplexer_tx_arbiter_if
    import spio_hss_multiplexer_tx_arbiter_pkg::*;
();
    logic [FRM_BITS-1:0]  frm_data;
    logic [KCH_BITS-1:0]  frm_kchr;
    logic                 frm_last;
    logic                 frm_vld;
    logic                 frm_rdy;
    logic                 ack_type;
    logic [CLR_BITS-1:0]  ack_colour;
    logic [SEQ_BITS-1:0]  ack_seq;
    logic                 ack_rts;
    logic                 ack_rtr;
    logic                 ooc_colour;
    logic                 ooc_rts;
    logic                 ooc_rtr;
    logic [NUM_CHANS-1:0] cfc_loc;
    logic                 reg_stop;
    logic                 reg_tfrm;
    logic [FRM_BITS-1:0]  hsl_data;
    logic [KCH_BITS-1:0]  hsl_kchr;
    logic                 hsl_vld;
    logic                 hsl_rdy;

    modport slave (
        input  frm_data, frm_kchr, frm_last, frm_vld,
        output frm_rdy,
        input  ack_type, ack_colour, ack_seq, ack_rts,
        output ack_rtr,
        input  ooc_colour, ooc_rts,
        output ooc_rtr,
        input  cfc_loc, reg_stop,
        output reg_tfrm,
        output hsl_data, hsl_kchr, hsl_vld,
        input  hsl_rdy
    );

    modport master (
        output frm_data, frm_kchr, frm_last, frm_vld,
        input  frm_rdy,
        output ack_type, ack_colour, ack_seq, ack_rts,
        input  ack_rtr,
        output ooc_colour, ooc_rts,
        input  ooc_rtr,
        output cfc_loc, reg_stop,
        input  reg_tfrm,
        input  hsl_data, hsl_kchr, hsl_vld,
        output hsl_rdy
    );

endinterface

// File: rtl/spio_hss_multiplexer_tx_arbiter_clkc.sv
// Clock-correction timer: free-running down counter raising a sticky pend flag once per INTERVAL cycles.
module spio_hss_multiplexer_clkc_timer
    import spio_hss_multiplexer_tx_arbiter_pkg::*;
#(
    parameter int INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pend
);

    localparam logic [15:0] RELOAD = 16'(INTERVAL - 1);

    logic [15:0] count;

    // A new expiry wins over a simultaneous clear so no interval is ever dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RELOAD;
            pend  <= 1'b0;
        end else if (count == '0) begin
            count <= RELOAD;
            pend  <= 1'b1;
        end else begin
            count <= count - 16'd1;
            if (clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_tx_arbiter.sv
// Shares the outgoing HSS link between data frames, ack/nack, OOC and idle/CLKC words.
// Optional clock-correction insertion is built when SPIO_HSS_MUX_CLKC_EN is defined.
module spio_hss_multiplexer_tx_arbiter
    import spio_hss_multiplexer_tx_arbiter_pkg::*;
#(
    parameter int CLKC_INTERVAL = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    spio_hss_multiplexer_tx_arbiter_if.slave      bus
);

    tx_state_e           state, state_n;
    logic                data_turn, data_turn_n;
    logic                load, frm_ok, hold_ctl;
    logic                clkc_pend, clkc_clr;
    logic                frm_rdy_c, ack_rtr_c, ooc_rtr_c;
    logic                vld_n;
    logic [FRM_BITS-1:0] data_n;
    logic [KCH_BITS-1:0] kchr_n;
    logic [FRM_BITS-1:0] hsl_data_q;
    logic [KCH_BITS-1:0] hsl_kchr_q;
    logic                hsl_vld_q, reg_tfrm_q;

`ifdef SPIO_HSS_MUX_CLKC_EN
    spio_hss_multiplexer_clkc_timer #(
        .INTERVAL (CLKC_INTERVAL)
    ) u_clkc_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clkc_clr),
        .pend (clkc_pend)
    );
`else
    logic unused_clkc;
    assign clkc_pend   = 1'b0;
    assign unused_clkc = clkc_clr | (CLKC_INTERVAL == 0);
`endif

    // Grants are combinational, so they are also held off while reset is asserted.
    assign load     = !rst && (!hsl_vld_q || bus.hsl_rdy);
    assign frm_ok   = bus.frm_vld && !bus.reg_stop;
    assign hold_ctl = data_turn && frm_ok;

    always_comb begin
        state_n     = state;
        data_turn_n = data_turn;
        frm_rdy_c   = 1'b0;
        ack_rtr_c   = 1'b0;
        ooc_rtr_c   = 1'b0;
        clkc_clr    = 1'b0;
        vld_n       = 1'b0;
        data_n      = '0;
        kchr_n      = '0;
        if (load) begin
            unique case (state)
                ST_BOUNDARY: begin
                    vld_n  = 1'b1;
                    kchr_n = CTL_KCHR;
                    if (clkc_pend) begin
                        data_n   = ctl_word(CODE_CLKC, bus.cfc_loc, '0, '0);
                        clkc_clr = 1'b1;
                    end else if (bus.ack_rts && !hold_ctl) begin
                        data_n    = ctl_word(bus.ack_type ? CODE_ACK : CODE_NAK,
                                             bus.cfc_loc, bus.ack_colour, bus.ack_seq);
                        ack_rtr_c = 1'b1;
                        if (frm_ok) data_turn_n = 1'b1;
                    end else if (bus.ooc_rts && !hold_ctl) begin
                        data_n    = ctl_word(CODE_OOC, bus.cfc_loc, CLR_BITS'(bus.ooc_colour), '0);
                        ooc_rtr_c = 1'b1;
                        if (frm_ok) data_turn_n = 1'b1;
                    end else if (frm_ok) begin
                        data_n      = bus.frm_data;
                        kchr_n      = bus.frm_kchr;
                        frm_rdy_c   = 1'b1;
                        data_turn_n = 1'b0;
                        if (!bus.frm_last) state_n = ST_DATA;
                    end else begin
                        data_n = ctl_word(CODE_IDLE, bus.cfc_loc, '0, '0);
                    end
                end
                ST_DATA: begin
                    // Mid-frame a missing word becomes a bubble rather than a control word.
                    if (bus.frm_vld) begin
                        vld_n       = 1'b1;
                        data_n      = bus.frm_data;
                        kchr_n      = bus.frm_kchr;
                        frm_rdy_c   = 1'b1;
                        data_turn_n = 1'b0;
                        if (bus.frm_last) state_n = ST_BOUNDARY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOUNDARY;
            data_turn  <= 1'b0;
            hsl_vld_q  <= 1'b0;
            hsl_data_q <= '0;
            hsl_kchr_q <= '0;
            reg_tfrm_q <= 1'b0;
        end else begin
            state      <= state_n;
            data_turn  <= data_turn_n;
            reg_tfrm_q <= frm_rdy_c && bus.frm_last;
            if (load) begin
                hsl_vld_q  <= vld_n;
                hsl_data_q <= data_n;
                hsl_kchr_q <= kchr_n;
            end
        end
    end

    assign bus.frm_rdy  = frm_rdy_c;
    assign bus.ack_rtr  = ack_rtr_c;
    assign bus.ooc_rtr  = ooc_rtr_c;
    assign bus.hsl_vld  = hsl_vld_q;
    assign bus.hsl_data = hsl_data_q;
    assign bus.hsl_kchr = hsl_kchr_q;
    assign bus.reg_tfrm = reg_tfrm_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_tx_arbiter.sv
// Directed bench for the HSS transmit arbiter; CLKC scenario built when SPIO_HSS_MUX_CLKC_EN is defined.
module tb_spio_hss_multiplexer_tx_arbiter;

    typedef logic [35:0] w_t;   // {kchr, data}
    typedef w_t wq_t[$];

    localparam logic [7:0] CFC = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spio_hss_multiplexer_tx_arbiter_if bus ();

    spio_hss_multiplexer_tx_arbiter #(
        .CLKC_INTERVAL (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [36:0] frm_q[$];      // {last, kchr, data}
    w_t          mon_q[$];
    int          mon_t[$];
    int          ack_set = 0, ack_done = 0, ooc_set = 0, ooc_done = 0;
    bit          acc_f, acc_a, acc_o;
    int          cyc = 0, tfrm_cnt = 0;

    // Link monitor and handshake sampling, away from the active edge.
    always @(negedge clk) begin
        acc_f = (bus.frm_vld === 1'b1) && (bus.frm_rdy === 1'b1);
        acc_a = (bus.ack_rts === 1'b1) && (bus.ack_rtr === 1'b1);
        acc_o = (bus.ooc_rts === 1'b1) && (bus.ooc_rtr === 1'b1);
        if (rst === 1'b0 && bus.hsl_vld === 1'b1 && bus.hsl_rdy === 1'b1) begin
            mon_q.push_back({bus.hsl_kchr, bus.hsl_data});
            mon_t.push_back(cyc);
        end
        if (bus.reg_tfrm === 1'b1) tfrm_cnt++;
    end

    // Source models: frame queue plus held ack/ooc requests.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (acc_f && frm_q.size() > 0) void'(frm_q.pop_front());
        if (acc_a) ack_done++;
        if (acc_o) ooc_done++;
        bus.ack_rts = (ack_set != ack_done);
        bus.ooc_rts = (ooc_set != ooc_done);
        if (frm_q.size() > 0) begin
            {bus.frm_last, bus.frm_kchr, bus.frm_data} = frm_q[0];
            bus.frm_vld = 1'b1;
        end else begin
            {bus.frm_last, bus.frm_kchr, bus.frm_data} = '0;
            bus.frm_vld = 1'b0;
        end
    end

    function automatic w_t ctl(input logic [7:0] code, input logic [7:0] col, input logic [7:0] seq);
        return {4'b1000, code, CFC, col, seq};
    endfunction

    function automatic bit is_fill(input w_t w);
        return (w[35:32] == 4'b1000) && (w[31:24] == 8'hBC || w[31:24] == 8'h9C);
    endfunction

    function automatic wq_t collect();
        wq_t r;
        foreach (mon_q[i]) if (!is_fill(mon_q[i])) r.push_back(mon_q[i]);
        return r;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((frm_q.size() != 0 || ack_set != ack_done || ooc_set != ooc_done) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (n >= 300) $display("FAIL %s_drain: sources still pending after %0d cycles, required drained", name, n);
        else passes++;
    endtask

    task automatic test_reset();
        bus.hsl_rdy = 1'b1; bus.reg_stop = 1'b0; bus.cfc_loc = CFC;
        bus.ack_type = 1'b0; bus.ack_colour = '0; bus.ack_seq = '0; bus.ooc_colour = 1'b0;
        rst = 1'b1;
        ack_set = ack_done + 1;
        ooc_set = ooc_done + 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.hsl_vld !== 1'b0) $display("FAIL rst_vld: got %b required 0", bus.hsl_vld); else passes++;
        checks++; if (bus.hsl_data !== 32'h0) $display("FAIL rst_data: got %h required 0", bus.hsl_data); else passes++;
        checks++; if (bus.hsl_kchr !== 4'h0) $display("FAIL rst_kchr: got %h required 0", bus.hsl_kchr); else passes++;
        checks++; if (bus.ack_rtr !== 1'b0) $display("FAIL rst_ack_rtr: got %b required 0", bus.ack_rtr); else passes++;
        checks++; if (bus.ooc_rtr !== 1'b0) $display("FAIL rst_ooc_rtr: got %b required 0", bus.ooc_rtr); else passes++;
        checks++; if (bus.frm_rdy !== 1'b0) $display("FAIL rst_frm_rdy: got %b required 0", bus.frm_rdy); else passes++;
        checks++; if (bus.reg_tfrm !== 1'b0) $display("FAIL rst_tfrm: got %b required 0", bus.reg_tfrm); else passes++;
        ack_set = ack_done;
        ooc_set = ooc_done;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.hsl_vld !== 1'b0) $display("FAIL rel_vld_before_edge: got %b required 0", bus.hsl_vld); else passes++;
        @(negedge clk);
        checks++; if (bus.hsl_vld !== 1'b1) $display("FAIL first_idle_vld: got %b required 1", bus.hsl_vld); else passes++;
        checks++;
        if ({bus.hsl_kchr, bus.hsl_data} !== ctl(8'hBC, 8'h00, 8'h00))
            $display("FAIL first_idle_word: got %h required %h", {bus.hsl_kchr, bus.hsl_data}, ctl(8'hBC, 8'h00, 8'h00));
        else passes++;
    endtask

    task automatic test_frame_ack();
        wq_t got, exp;
        int  t0 = tfrm_cnt;
        int  n = 0;
        int  idx = -1;
        @(posedge clk); #2;
        mon_q.delete(); mon_t.delete();
        frm_q.push_back({1'b0, 4'b0010, 32'h1111_0001});
        frm_q.push_back({1'b0, 4'b0000, 32'h2222_0002});
        frm_q.push_back({1'b1, 4'b0000, 32'h3333_0003});
        while (frm_q.size() != 2 && n < 50) begin @(posedge clk); #2; n++; end
        bus.ack_type = 1'b1; bus.ack_colour = 1'b1; bus.ack_seq = 7'h15;
        ack_set++;
        wait_drain("frame_ack");
        exp.push_back({4'b0010, 32'h1111_0001});
        exp.push_back({4'b0000, 32'h2222_0002});
        exp.push_back({4'b0000, 32'h3333_0003});
        exp.push_back(ctl(8'h3C, 8'h01, 8'h15));
        got = collect();
        checks++; if (got.size() != exp.size()) $display("FAIL frame_ack_len: got %0d words required %0d", got.size(), exp.size()); else passes++;
        foreach (exp[i]) begin
            w_t g;
            g = (i < got.size()) ? got[i] : '1;
            checks++; if (g !== exp[i]) $display("FAIL frame_ack_w%0d: got %h required %h", i, g, exp[i]); else passes++;
        end
        foreach (mon_q[i]) if (idx < 0 && mon_q[i] == exp[0]) idx = i;
        checks++;
        if (idx < 0 || idx + 2 >= mon_q.size() || mon_q[idx+1] !== exp[1] || mon_q[idx+2] !== exp[2])
            $display("FAIL frame_contig: word 1 at index %0d of %0d, words 2/3 not adjacent", idx, mon_q.size());
        else passes++;
        checks++; if (tfrm_cnt - t0 != 1) $display("FAIL frame_tfrm: got %0d pulses required 1", tfrm_cnt - t0); else passes++;
    endtask

    task automatic test_priority();
        wq_t got, exp;
        @(posedge clk); #2;
        mon_q.delete(); mon_t.delete();
        frm_q.push_back({1'b0, 4'b0000, 32'hE1E1_0001});
        frm_q.push_back({1'b1, 4'b0000, 32'hE2E2_0002});
        bus.ack_type = 1'b0; bus.ack_colour = 1'b0; bus.ack_seq = 7'h03;
        bus.ooc_colour = 1'b1;
        ack_set++;
        ooc_set++;
        wait_drain("priority");
        exp.push_back(ctl(8'h5C, 8'h00, 8'h03));
        exp.push_back({4'b0000, 32'hE1E1_0001});
        exp.push_back({4'b0000, 32'hE2E2_0002});
        exp.push_back(ctl(8'h7C, 8'h01, 8'h00));
        got = collect();
        checks++; if (got.size() != exp.size()) $display("FAIL priority_len: got %0d words required %0d", got.size(), exp.size()); else passes++;
        foreach (exp[i]) begin
            w_t g;
            g = (i < got.size()) ? got[i] : '1;
            checks++; if (g !== exp[i]) $display("FAIL priority_w%0d: got %h required %h", i, g, exp[i]); else passes++;
        end
    endtask

    task automatic test_stall();
        wq_t got, exp;
        int  n = 0;
        @(posedge clk); #2;
        mon_q.delete(); mon_t.delete();
        for (int w = 1; w <= 4; w++) begin
            logic [31:0] d;
            d = 32'hF000_0000 | 32'(w);
            frm_q.push_back({(w == 4), 4'b0001, d});
            exp.push_back({4'b0001, d});
        end
        do begin @(negedge clk); n++; end while (!(bus.hsl_vld === 1'b1 && bus.hsl_data === 32'hF000_0002) && n < 50);
        @(posedge clk); #2;
        bus.hsl_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.hsl_data !== 32'hF000_0003) $display("FAIL stall_data%0d: got %h required f0000003", c, bus.hsl_data); else passes++;
            checks++; if (bus.hsl_vld !== 1'b1) $display("FAIL stall_vld%0d: got %b required 1", c, bus.hsl_vld); else passes++;
            checks++; if (bus.frm_rdy !== 1'b0) $display("FAIL stall_frm_rdy%0d: got %b required 0", c, bus.frm_rdy); else passes++;
        end
        @(posedge clk); #2;
        bus.hsl_rdy = 1'b1;
        wait_drain("stall");
        got = collect();
        checks++; if (got.size() != exp.size()) $display("FAIL stall_len: got %0d words required %0d", got.size(), exp.size()); else passes++;
        foreach (exp[i]) begin
            w_t g;
            g = (i < got.size()) ? got[i] : '1;
            checks++; if (g !== exp[i]) $display("FAIL stall_w%0d: got %h required %h", i, g, exp[i]); else passes++;
        end
    endtask

    task automatic test_stop();
        wq_t got;
        int  grants = 0;
        int  nonfill = 0;
        int  t0;
        @(posedge clk); #2;
        bus.reg_stop = 1'b1;
        mon_q.delete(); mon_t.delete();
        t0 = tfrm_cnt;
        frm_q.push_back({1'b1, 4'b0000, 32'h6060_0001});
        repeat (10) begin
            @(negedge clk);
            if (bus.frm_rdy === 1'b1) grants++;
        end
        foreach (mon_q[i]) if (!is_fill(mon_q[i])) nonfill++;
        checks++; if (grants != 0) $display("FAIL stop_grants: got %0d frm_rdy cycles required 0", grants); else passes++;
        checks++; if (nonfill != 0) $display("FAIL stop_idle_only: got %0d non-idle words required 0", nonfill); else passes++;
        checks++; if (mon_q.size() < 9) $display("FAIL stop_link_busy: got %0d idle words required >=9", mon_q.size()); else passes++;
        @(posedge clk); #2;
        bus.reg_stop = 1'b0;
        wait_drain("stop");
        got = collect();
        checks++;
        if (got.size() != 1 || got[0] !== {4'b0000, 32'h6060_0001})
            $display("FAIL stop_release: got %0d words first %h required 1 word 060600001", got.size(), (got.size() > 0) ? got[0] : '1);
        else passes++;
        checks++; if (tfrm_cnt - t0 != 1) $display("FAIL stop_tfrm: got %0d pulses required 1", tfrm_cnt - t0); else passes++;
    endtask

    task automatic test_reset_mid();
        wq_t got;
        int  n = 0;
        @(posedge clk); #2;
        for (int w = 1; w <= 4; w++) frm_q.push_back({(w == 4), 4'b0000, 32'h7070_0000 | 32'(w)});
        do begin @(negedge clk); n++; end while (!(bus.hsl_vld === 1'b1 && bus.hsl_data === 32'h7070_0002) && n < 50);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.hsl_vld !== 1'b0) $display("FAIL midrst_vld: got %b required 0", bus.hsl_vld); else passes++;
        checks++; if (bus.frm_rdy !== 1'b0) $display("FAIL midrst_frm_rdy: got %b required 0", bus.frm_rdy); else passes++;
        checks++; if (bus.hsl_data !== 32'h0) $display("FAIL midrst_data: got %h required 0", bus.hsl_data); else passes++;
        frm_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        mon_q.delete(); mon_t.delete();
        bus.ack_type = 1'b1; bus.ack_colour = 1'b0; bus.ack_seq = 7'h7F;
        ack_set++;
        wait_drain("reset_mid");
        got = collect();
        checks++;
        if (got.size() != 1 || got[0] !== ctl(8'h3C, 8'h00, 8'h7F))
            $display("FAIL midrst_boundary_ack: got %0d words first %h required %h", got.size(), (got.size() > 0) ? got[0] : '1, ctl(8'h3C, 8'h00, 8'h7F));
        else passes++;
    endtask

`ifdef SPIO_HSS_MUX_CLKC_EN
    task automatic test_clkc();
        int inframe = 0;
        int ndata = 0;
        int last_t = -1;
        int nclkc = 0;
        @(posedge clk); #2;
        mon_q.delete(); mon_t.delete();
        for (int f = 0; f < 12; f++)
            for (int w = 0; w < 4; w++) frm_q.push_back({(w == 3), 4'b0000, 32'(f * 16 + w)});
        wait_drain("clkc");
        foreach (mon_q[i]) begin
            if (mon_q[i][35:32] == 4'b1000 && mon_q[i][31:24] == 8'h9C) begin
                nclkc++;
                checks++; if (inframe != 0) $display("FAIL clkc_mid_frame: CLKC after %0d words of a frame, required 0", inframe); else passes++;
                if (last_t >= 0) begin
                    checks++;
                    if (mon_t[i] - last_t < 13 || mon_t[i] - last_t > 19)
                        $display("FAIL clkc_gap: got %0d cycles required 13..19", mon_t[i] - last_t);
                    else passes++;
                end
                last_t = mon_t[i];
            end else if (mon_q[i][35:32] == 4'b0000) begin
                ndata++;
                inframe = (inframe + 1) % 4;
            end
        end
        checks++; if (nclkc < 3) $display("FAIL clkc_count: got %0d CLKC words required >=3", nclkc); else passes++;
        checks++; if (ndata != 48) $display("FAIL clkc_data_count: got %0d data words required 48", ndata); else passes++;
    endtask
`else
    task automatic test_no_clkc();
        int nclkc = 0;
        @(posedge clk); #2;
        mon_q.delete(); mon_t.delete();
        repeat (40) @(posedge clk);
        #2;
        foreach (mon_q[i]) if (mon_q[i][31:24] == 8'h9C) nclkc++;
        checks++; if (nclkc != 0) $display("FAIL no_clkc: got %0d CLKC words required 0", nclkc); else passes++;
        checks++; if (mon_q.size() < 39) $display("FAIL no_clkc_idle: got %0d idle words required >=39", mon_q.size()); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_frame_ack();
        test_priority();
        test_stall();
        test_stop();
        test_reset_mid();
`ifdef SPIO_HSS_MUX_CLKC_EN
        test_clkc();
`else
        test_no_clkc();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
